// File: rtl/branch_fetch_control_if.sv
// Control bundle between the fetch/branch sequencer and the datapath.
// master = sequencer (drives controls), slave = datapath side.
interface branch_fetch_control_if;
  logic        run_en;
  logic [31:0] IR_Data;
  logic        CON_out;

  logic PC_out, MAR_in, IncPC, Read, MDR_in, MDR_out, IR_in;
  logic Gra, Grb, Grc, Rin, Rout, BAout;
  logic Y_in, Z_in, Zlow_out, C_out, PC_in;
  logic [4:0] alu_instruction_bits;
  logic instr_done, branch_taken, halted, illegal;

  modport master (
    input  run_en, IR_Data, CON_out,
    output PC_out, MAR_in, IncPC, Read, MDR_in, MDR_out, IR_in,
           Gra, Grb, Grc, Rin, Rout, BAout,
           Y_in, Z_in, Zlow_out, C_out, PC_in, alu_instruction_bits,
           instr_done, branch_taken, halted, illegal
  );

  modport slave (
    output run_en, IR_Data, CON_out,
    input  PC_out, MAR_in, IncPC, Read, MDR_in, MDR_out, IR_in,
           Gra, Grb, Grc, Rin, Rout, BAout,
           Y_in, Z_in, Zlow_out, C_out, PC_in, alu_instruction_bits,
           instr_done, branch_taken, halted, illegal
  );
endinterface

// File: rtl/branch_fetch_control.sv
// Hardwired fetch + program-flow sequencer (br/jr/nop/halt) driving datapath controls.
// Fetch takes 2+MEM_LAT cycles; br adds 4, jr/nop/halt add 1; run_en only sampled at instruction boundaries.
module branch_fetch_control #(
  parameter int       MEM_LAT = 1,
  parameter bit [4:0] ALU_ADD = 5'b00011,
  parameter bit [4:0] OP_BR   = 5'b10010,
  parameter bit [4:0] OP_JR   = 5'b10100,
  parameter bit [4:0] OP_NOP  = 5'b11010,
  parameter bit [4:0] OP_HALT = 5'b11011
) (
  input  logic                          clk,
  input  logic                          clr,
  branch_fetch_control_if.master        ctl
);

  typedef enum logic [3:0] {
    IDLE, T0, T1, T2, T3, T4, T5, T6, HALT
  } state_t;

  localparam logic [3:0] LAT_LAST = 4'(MEM_LAT - 1);

  state_t     state, state_nxt;
  logic [3:0] lat_cnt;
  logic       illegal_q;
  logic [4:0] opcode;
  logic       op_legal;
  logic       unused_ir;

  assign opcode    = ctl.IR_Data[31:27];
  assign unused_ir = ^ctl.IR_Data[26:0];
  assign op_legal  = (opcode == OP_BR) || (opcode == OP_JR) ||
                     (opcode == OP_NOP) || (opcode == OP_HALT);

  always_ff @(posedge clk) begin
    if (clr) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (ctl.run_en) state_nxt = T0;
      T0:   state_nxt = T1;
      T1:   if (lat_cnt == LAT_LAST) state_nxt = T2;
      T2:   state_nxt = T3;
      T3: begin
        if (opcode == OP_BR)        state_nxt = T4;
        else if (opcode == OP_HALT) state_nxt = HALT;
        else                        state_nxt = ctl.run_en ? T0 : IDLE;
      end
      T4:   state_nxt = T5;
      T5:   state_nxt = T6;
      T6:   state_nxt = ctl.run_en ? T0 : IDLE;
      HALT: state_nxt = HALT;
      default: state_nxt = IDLE;
    endcase
  end

  // Counter only advances while staying in T1, so it is zero on every entry.
  always_ff @(posedge clk) begin
    if (clr)                                  lat_cnt <= 4'd0;
    else if (state == T1 && state_nxt == T1)  lat_cnt <= lat_cnt + 4'd1;
    else                                      lat_cnt <= 4'd0;
  end

  always_ff @(posedge clk) begin
    if (clr)                           illegal_q <= 1'b0;
    else if (state == T3 && !op_legal) illegal_q <= 1'b1;
  end

  assign ctl.illegal = illegal_q;

  always_comb begin
    ctl.PC_out = 1'b0; ctl.MAR_in = 1'b0; ctl.IncPC = 1'b0; ctl.Read = 1'b0;
    ctl.MDR_in = 1'b0; ctl.MDR_out = 1'b0; ctl.IR_in = 1'b0;
    ctl.Gra = 1'b0; ctl.Grb = 1'b0; ctl.Grc = 1'b0; ctl.Rin = 1'b0;
    ctl.Rout = 1'b0; ctl.BAout = 1'b0;
    ctl.Y_in = 1'b0; ctl.Z_in = 1'b0; ctl.Zlow_out = 1'b0; ctl.C_out = 1'b0;
    ctl.PC_in = 1'b0;
    ctl.alu_instruction_bits = 5'd0;
    ctl.instr_done = 1'b0; ctl.branch_taken = 1'b0; ctl.halted = 1'b0;
    case (state)
      T0: begin ctl.PC_out = 1'b1; ctl.MAR_in = 1'b1; ctl.IncPC = 1'b1; end
      T1: begin ctl.Read = 1'b1; ctl.MDR_in = 1'b1; end
      T2: begin ctl.MDR_out = 1'b1; ctl.IR_in = 1'b1; end
      T3: begin
        // br reads its register here so the CON flip-flop loads at the end of T3.
        if (opcode == OP_BR || opcode == OP_JR) begin
          ctl.Gra  = 1'b1;
          ctl.Rout = 1'b1;
        end
        ctl.PC_in      = (opcode == OP_JR);
        ctl.instr_done = (opcode != OP_BR);
      end
      T4: begin ctl.PC_out = 1'b1; ctl.Y_in = 1'b1; end
      T5: begin ctl.C_out = 1'b1; ctl.Z_in = 1'b1; ctl.alu_instruction_bits = ALU_ADD; end
      T6: begin
        ctl.Zlow_out     = 1'b1;
        ctl.instr_done   = 1'b1;
        ctl.PC_in        = ctl.CON_out;
        ctl.branch_taken = ctl.CON_out;
      end
      HALT: ctl.halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_branch_fetch_control.sv
// Bench for branch_fetch_control: per-cycle expected control vectors are queued
// when an instruction is issued and popped against the DUT each cycle.
module tb_branch_fetch_control;

  logic clk;
  logic clr;

  branch_fetch_control_if bif1();
  branch_fetch_control_if bif3();

  branch_fetch_control #(.MEM_LAT(1)) dut1 (.clk(clk), .clr(clr), .ctl(bif1.master));
  branch_fetch_control #(.MEM_LAT(3)) dut3 (.clk(clk), .clr(clr), .ctl(bif3.master));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [26:0] V_PC_OUT   = 27'd1 << 26;
  localparam logic [26:0] V_MAR_IN   = 27'd1 << 25;
  localparam logic [26:0] V_INCPC    = 27'd1 << 24;
  localparam logic [26:0] V_READ     = 27'd1 << 23;
  localparam logic [26:0] V_MDR_IN   = 27'd1 << 22;
  localparam logic [26:0] V_MDR_OUT  = 27'd1 << 21;
  localparam logic [26:0] V_IR_IN    = 27'd1 << 20;
  localparam logic [26:0] V_GRA      = 27'd1 << 19;
  localparam logic [26:0] V_ROUT     = 27'd1 << 15;
  localparam logic [26:0] V_Y_IN     = 27'd1 << 13;
  localparam logic [26:0] V_Z_IN     = 27'd1 << 12;
  localparam logic [26:0] V_ZLOW     = 27'd1 << 11;
  localparam logic [26:0] V_C_OUT    = 27'd1 << 10;
  localparam logic [26:0] V_PC_IN    = 27'd1 << 9;
  localparam logic [26:0] V_ALU_ADD  = 27'd3 << 4;
  localparam logic [26:0] V_DONE     = 27'd1 << 3;
  localparam logic [26:0] V_TAKEN    = 27'd1 << 2;
  localparam logic [26:0] V_HALTED   = 27'd1 << 1;
  localparam logic [26:0] V_ILLEGAL  = 27'd1;
  localparam logic [26:0] V_ZERO     = 27'd0;

  localparam logic [31:0] I_BRZR = 32'h9100_0023;
  localparam logic [31:0] I_JR   = {5'b10100, 27'h0000123};
  localparam logic [31:0] I_NOP  = {5'b11010, 27'h0};
  localparam logic [31:0] I_HALT = {5'b11011, 27'h0};
  localparam logic [31:0] I_BAD  = {5'b00011, 27'h0ABCDEF};

  logic [26:0] obs1, obs3;
  logic [4:0]  drv1, drv3;

  assign obs1 = {bif1.PC_out, bif1.MAR_in, bif1.IncPC, bif1.Read, bif1.MDR_in, bif1.MDR_out,
                 bif1.IR_in, bif1.Gra, bif1.Grb, bif1.Grc, bif1.Rin, bif1.Rout, bif1.BAout,
                 bif1.Y_in, bif1.Z_in, bif1.Zlow_out, bif1.C_out, bif1.PC_in,
                 bif1.alu_instruction_bits, bif1.instr_done, bif1.branch_taken,
                 bif1.halted, bif1.illegal};
  assign obs3 = {bif3.PC_out, bif3.MAR_in, bif3.IncPC, bif3.Read, bif3.MDR_in, bif3.MDR_out,
                 bif3.IR_in, bif3.Gra, bif3.Grb, bif3.Grc, bif3.Rin, bif3.Rout, bif3.BAout,
                 bif3.Y_in, bif3.Z_in, bif3.Zlow_out, bif3.C_out, bif3.PC_in,
                 bif3.alu_instruction_bits, bif3.instr_done, bif3.branch_taken,
                 bif3.halted, bif3.illegal};
  assign drv1 = {bif1.PC_out, bif1.MDR_out, bif1.Rout, bif1.Zlow_out, bif1.C_out};
  assign drv3 = {bif3.PC_out, bif3.MDR_out, bif3.Rout, bif3.Zlow_out, bif3.C_out};

  int n_checks = 0;
  int n_errors = 0;
  logic [26:0] exp_q[$];
  logic        ill_m;
  logic        onehot_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  always @(negedge clk) begin
    if (onehot_en) begin
      check("drv_onehot_lat1", {31'd0, $countones(drv1) <= 1}, 32'd1);
      check("drv_onehot_lat3", {31'd0, $countones(drv3) <= 1}, 32'd1);
    end
  end

  function automatic logic [26:0] im();
    return ill_m ? V_ILLEGAL : V_ZERO;
  endfunction

  task automatic drive(input int sel, input logic run, input logic [31:0] ir, input logic con);
    if (sel == 1) begin
      bif1.run_en = run; bif1.IR_Data = ir; bif1.CON_out = con;
    end else begin
      bif3.run_en = run; bif3.IR_Data = ir; bif3.CON_out = con;
    end
  endtask

  task automatic do_reset();
    clr = 1'b1;
    drive(1, 1'b0, 32'd0, 1'b0);
    drive(3, 1'b0, 32'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1 clr = 1'b0;
    ill_m = 1'b0;
  endtask

  // Expected per-cycle outputs of one instruction, starting at T0.
  task automatic push_instr(input int lat, input logic [31:0] ir, input logic con);
    logic [4:0] op;
    op = ir[31:27];
    exp_q.push_back(V_PC_OUT | V_MAR_IN | V_INCPC | im());
    repeat (lat) exp_q.push_back(V_READ | V_MDR_IN | im());
    exp_q.push_back(V_MDR_OUT | V_IR_IN | im());
    case (op)
      5'b10010: begin
        exp_q.push_back(V_GRA | V_ROUT | im());
        exp_q.push_back(V_PC_OUT | V_Y_IN | im());
        exp_q.push_back(V_C_OUT | V_Z_IN | V_ALU_ADD | im());
        exp_q.push_back(V_ZLOW | V_DONE | (con ? (V_PC_IN | V_TAKEN) : V_ZERO) | im());
      end
      5'b10100: exp_q.push_back(V_GRA | V_ROUT | V_PC_IN | V_DONE | im());
      5'b11010, 5'b11011: exp_q.push_back(V_DONE | im());
      default: begin
        exp_q.push_back(V_DONE | im());
        ill_m = 1'b1;
      end
    endcase
  endtask

  task automatic consume(input int sel, input string tag, input int drop_idx, input int clr_idx);
    int i;
    logic [26:0] e;
    i = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      check($sformatf("%s[%0d]", tag, i), {5'd0, (sel == 1) ? obs1 : obs3}, {5'd0, e});
      if (i == drop_idx) begin
        if (sel == 1) bif1.run_en = 1'b0;
        else          bif3.run_en = 1'b0;
      end
      if (i == clr_idx) clr = 1'b1;
      i++;
    end
  endtask

  initial begin
    clr = 1'b1;
    ill_m = 1'b0;
    drive(1, 1'b0, 32'd0, 1'b0);
    drive(3, 1'b0, 32'd0, 1'b0);
    @(negedge clk);
    onehot_en = 1'b1;

    do_reset();
    repeat (5) exp_q.push_back(V_ZERO);
    consume(1, "idle", -1, -1);

    // brzr not taken, run_en dropped mid-instruction -> IDLE afterwards
    do_reset();
    drive(1, 1'b1, I_BRZR, 1'b0);
    exp_q.push_back(V_ZERO);
    push_instr(1, I_BRZR, 1'b0);
    repeat (2) exp_q.push_back(V_ZERO);
    consume(1, "br_nt", 1, -1);

    do_reset();
    drive(1, 1'b1, I_BRZR, 1'b1);
    exp_q.push_back(V_ZERO);
    push_instr(1, I_BRZR, 1'b1);
    push_instr(1, I_BRZR, 1'b1);
    consume(1, "br_tk", -1, -1);

    do_reset();
    drive(1, 1'b1, I_JR, 1'b1);
    exp_q.push_back(V_ZERO);
    push_instr(1, I_JR, 1'b1);
    push_instr(1, I_JR, 1'b1);
    consume(1, "jr", -1, -1);

    do_reset();
    drive(1, 1'b1, I_NOP, 1'b1);
    exp_q.push_back(V_ZERO);
    push_instr(1, I_NOP, 1'b1);
    push_instr(1, I_NOP, 1'b1);
    repeat (2) exp_q.push_back(V_ZERO);
    consume(1, "nop", 6, -1);

    // MEM_LAT=3: two illegal instructions, idle, then a nop with illegal still set
    do_reset();
    drive(3, 1'b1, I_BAD, 1'b0);
    exp_q.push_back(V_ZERO);
    push_instr(3, I_BAD, 1'b0);
    push_instr(3, I_BAD, 1'b0);
    repeat (2) exp_q.push_back(V_ILLEGAL);
    consume(3, "ill", 8, -1);
    drive(3, 1'b1, I_NOP, 1'b0);
    push_instr(3, I_NOP, 1'b0);
    consume(3, "ill_nop", -1, -1);

    do_reset();
    drive(1, 1'b1, I_HALT, 1'b0);
    exp_q.push_back(V_ZERO);
    push_instr(1, I_HALT, 1'b0);
    repeat (6) exp_q.push_back(V_HALTED);
    consume(1, "halt", -1, -1);

    // clr during T4 of a br: back to IDLE with no PC_in or instr_done
    do_reset();
    drive(1, 1'b1, I_BRZR, 1'b1);
    exp_q.push_back(V_ZERO);
    push_instr(1, I_BRZR, 1'b1);
    while (exp_q.size() > 6) void'(exp_q.pop_back());
    repeat (3) exp_q.push_back(V_ZERO);
    consume(1, "clr_mid", -1, 5);
    #1 clr = 1'b0;
    drive(1, 1'b0, 32'd0, 1'b0);
    repeat (2) exp_q.push_back(V_ZERO);
    consume(1, "post_clr", -1, -1);

    onehot_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
